// File: rtl/bsr_pkg.sv
// Shared definitions for the barrel-shift datapath family: default width,
// shift-direction encoding and the serialiser state type.
package bsr_pkg;

    localparam int unsigned BSR_WIDTH = 16;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } bsr_piso_state_t;

endpackage

// File: rtl/bsr_piso.sv
// Parallel-in serial-out transmitter: takes a word over valid/ready and emits
// it one bit per accepted beat, MSB-first or LSB-first per word.
module bsr_piso
    import bsr_pkg::*;
#(
    parameter int unsigned WIDTH = BSR_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             shiftdr,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    input  logic             sout_ready
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);

    bsr_piso_state_t state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d;

    logic load;
    logic beat;

    // Output side depends only on registered state.
    always_comb begin
        sout_valid = (state_q == SHIFT);
        sout_last  = sout_valid && (cnt_q == CntLast);
        sout       = 1'b0;
        if (sout_valid) begin
            sout = (dir_q == DIR_RIGHT) ? shreg_q[0] : shreg_q[WIDTH-1];
        end
    end

    // Reload is allowed only as the last bit leaves, so words run back-to-back.
    assign din_ready = (state_q == IDLE) || (sout_last && sout_ready);
    assign load      = din_valid && din_ready;
    assign beat      = sout_valid && sout_ready;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        if (load) begin
            shreg_d = din;
            dir_d   = shiftdr;
            cnt_d   = '0;
            state_d = SHIFT;
        end else if (beat) begin
            shreg_d = (dir_q == DIR_RIGHT) ? (shreg_q >> 1) : (shreg_q << 1);
            if (sout_last) begin
                cnt_d   = '0;
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            dir_q   <= DIR_LEFT;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

endmodule

// File: tb/tb_bsr_piso.sv
// Self-checking bench for bsr_piso: a bit-queue model checked every cycle,
// plus literal expectations on the captured serial streams.
module tb_bsr_piso;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] din = '0;
    logic         shiftdr = 1'b0;
    logic         din_valid = 1'b0;
    logic         din_ready;
    logic         sout;
    logic         sout_valid;
    logic         sout_last;
    logic         sout_ready = 1'b1;

    bsr_piso #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .shiftdr    (shiftdr),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .sout_last  (sout_last),
        .sout_ready (sout_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_loads = 0;
    bit en = 1'b0;

    logic mq[$];     // bits still owed on the serial link, front = next bit
    logic cap[$];    // bits seen on accepted beats
    logic cap_last[$];
    int   cap_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a word becomes W queued bits; a beat pops one; a new word is
    // accepted when nothing is owed or the final owed bit leaves this cycle.
    always @(posedge clk) begin
        bit mrdy;
        cyc++;
        mrdy = (mq.size() == 0) || (mq.size() == 1 && sout_ready);
        if (rst) begin
            mq.delete();
        end else begin
            if (mq.size() > 0 && sout_ready) void'(mq.pop_front());
            if (din_valid && mrdy) begin
                for (int i = 0; i < W; i++)
                    mq.push_back(shiftdr ? din[i] : din[W-1-i]);
                n_loads++;
            end
        end
    end

    always @(negedge clk) begin
        if (en) begin
            chk("sout_valid", 32'(sout_valid), 32'(mq.size() > 0));
            chk("sout_last", 32'(sout_last), 32'(mq.size() == 1));
            chk("din_ready", 32'(din_ready),
                32'((mq.size() == 0) || (mq.size() == 1 && sout_ready)));
            if (mq.size() > 0) chk("sout", 32'(sout), 32'(mq[0]));
            if (sout_valid && sout_ready) begin
                cap.push_back(sout);
                cap_last.push_back(sout_last);
                cap_cyc.push_back(cyc);
            end
        end
    end

    task automatic clear_cap();
        cap.delete();
        cap_last.delete();
        cap_cyc.delete();
    endtask

    task automatic wait_loads(input int target);
        int k;
        for (k = 0; k < 200; k++) begin
            @(posedge clk);
            #1;
            if (n_loads >= target) break;
        end
        if (k == 200) chk("load_timeout", 32'(n_loads), 32'(target));
    endtask

    task automatic send(input logic [W-1:0] w, input logic d);
        int t;
        t = n_loads + 1;
        din = w;
        shiftdr = d;
        din_valid = 1'b1;
        wait_loads(t);
        din_valid = 1'b0;
        din = 'x;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 400; k++) begin
            @(posedge clk);
            #1;
            if (mq.size() == 0) break;
        end
        if (k == 400) chk("idle_timeout", 32'(mq.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic chk_stream(input string name, input logic [W-1:0] exp_seq);
        chk({name, "_beats"}, 32'(cap.size()), 32'(W));
        for (int i = 0; i < W && i < cap.size(); i++) begin
            chk({name, "_bit"}, 32'(cap[i]), 32'(exp_seq[W-1-i]));
            chk({name, "_lastflag"}, 32'(cap_last[i]), 32'(i == W - 1));
        end
    endtask

    initial begin
        int k;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        en = 1'b1;
        @(negedge clk);
        chk("reset_valid", 32'(sout_valid), 32'd0);
        chk("reset_ready", 32'(din_ready), 32'd1);
        chk("reset_last", 32'(sout_last), 32'd0);
        chk("reset_sout", 32'(sout), 32'd0);

        // A5C3 MSB-first: 1010 0101 1100 0011
        @(posedge clk); #1;
        clear_cap();
        send(16'hA5C3, 1'b0);
        wait_idle();
        chk_stream("a5c3_msb", 16'b1010_0101_1100_0011);
        chk("a5c3_gapless", 32'(cap_cyc[W-1] - cap_cyc[0]), 32'(W - 1));
        chk("a5c3_idle_ready", 32'(din_ready), 32'd1);

        // 0001 LSB-first: 1 then fifteen zeros
        clear_cap();
        send(16'h0001, 1'b1);
        wait_idle();
        chk_stream("0001_lsb", 16'b1000_0000_0000_0000);

        // 0001 MSB-first: fifteen zeros then 1
        clear_cap();
        send(16'h0001, 1'b0);
        wait_idle();
        chk_stream("0001_msb", 16'b0000_0000_0000_0001);

        // Backpressure with ready pattern 1,0,0,1
        clear_cap();
        din = 16'hA5C3;
        shiftdr = 1'b0;
        din_valid = 1'b1;
        k = n_loads + 1;
        wait_loads(k);
        din_valid = 1'b0;
        for (int i = 0; i < 200 && mq.size() > 0; i++) begin
            sout_ready = (i % 4 == 0) || (i % 4 == 3);
            shiftdr = ~shiftdr;  // must not affect the word in flight
            @(posedge clk);
            #1;
        end
        sout_ready = 1'b1;
        @(negedge clk);
        chk_stream("bp_a5c3", 16'b1010_0101_1100_0011);

        // Back-to-back FFFF (left) then 0000 (right), valid held high
        clear_cap();
        din = 16'hFFFF;
        shiftdr = 1'b0;
        din_valid = 1'b1;
        k = n_loads;
        wait_loads(k + 1);
        din = 16'h0000;
        shiftdr = 1'b1;
        wait_loads(k + 2);
        din_valid = 1'b0;
        wait_idle();
        chk("b2b_beats", 32'(cap.size()), 32'd32);
        if (cap.size() == 32) begin
            for (int i = 0; i < 32; i++) begin
                chk("b2b_bit", 32'(cap[i]), 32'(i < 16));
                chk("b2b_last", 32'(cap_last[i]), 32'(i == 15 || i == 31));
            end
            chk("b2b_gapless", 32'(cap_cyc[31] - cap_cyc[0]), 32'd31);
        end

        // Reset mid-word
        clear_cap();
        send(16'hA5C3, 1'b0);
        for (k = 0; k < 100 && cap.size() < 5; k++) begin
            @(posedge clk);
            #1;
        end
        chk("mid_beats_seen", 32'(cap.size() >= 5), 32'd1);
        rst = 1'b1;
        din = 16'hFFFF;
        din_valid = 1'b1;  // reset must win over this load
        @(posedge clk);
        #1;
        rst = 1'b0;
        din_valid = 1'b0;
        @(negedge clk);
        chk("postrst_valid", 32'(sout_valid), 32'd0);
        chk("postrst_ready", 32'(din_ready), 32'd1);
        chk("postrst_last", 32'(sout_last), 32'd0);
        chk("postrst_loads", 32'(cap_last.sum() with (32'(item))), 32'd0);
        @(posedge clk); #1;
        clear_cap();
        send(16'h8000, 1'b0);
        wait_idle();
        chk_stream("post_8000", 16'b1000_0000_0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
